// File: rtl/fpu_op_scheduler_pkg.sv
// Shared types and constants for the two-requester FPU operation scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_sched_pkg;

  localparam int NREQ   = 2;
  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd2;
  localparam logic [OP_W-1:0] OP_SQRT = 3'd3;
  localparam logic [OP_W-1:0] OP_CMP  = 3'd4;
  localparam logic [OP_W-1:0] OP_MAX  = OP_CMP;

  // Flag bit positions: {inexact, ov, un, less, eq, great, inv, div_zero}
  localparam int FLG_DIV_ZERO = 0;
  localparam int FLG_INV      = 1;
  localparam int FLG_GREAT    = 2;
  localparam int FLG_EQ       = 3;
  localparam int FLG_LESS     = 4;
  localparam int FLG_UN       = 5;
  localparam int FLG_OV       = 6;
  localparam int FLG_INEXACT  = 7;

  // Reported for opcodes the FPU does not implement
  localparam logic [FLAG_W-1:0] FLAGS_INV_ONLY = 8'b1 << FLG_INV;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [OP_W-1:0]   rm;
  } fpu_cmd_t;

  typedef struct packed {
    logic              id;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              timeout;
  } fpu_rsp_t;

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Bundles requester, response and FPU-side pins of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: req valid/ready per requester, rsp valid/ready toward the consumer.
interface fpu_op_scheduler_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_opcode;
  logic [5:0]  req_rm;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_flags;
  logic        rsp_timeout;
  logic        busy;

  logic [31:0] fpu_in1;
  logic [31:0] fpu_in2;
  logic [2:0]  fpu_opcode;
  logic [2:0]  fpu_round;
  logic        fpu_rstp;
  logic        fpu_act;
  logic [31:0] fpu_out;
  logic [7:0]  fpu_flags;
  logic        fpu_done;

  // Environment side: requesters, response consumer and the FPU itself
  modport master (
    output req_valid, req_a, req_b, req_opcode, req_rm, rsp_ready,
           fpu_out, fpu_flags, fpu_done,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_timeout, busy,
           fpu_in1, fpu_in2, fpu_opcode, fpu_round, fpu_rstp, fpu_act
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, req_opcode, req_rm, rsp_ready,
           fpu_out, fpu_flags, fpu_done,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_timeout, busy,
           fpu_in1, fpu_in2, fpu_opcode, fpu_round, fpu_rstp, fpu_act
  );

endinterface

// File: rtl/fpu_op_scheduler_rr_arbiter.sv
// Two-way round-robin grant selection; the last-grant register lives in the parent.
// Latency: combinational.
// Backpressure: none; the parent decides when a grant is usable.
module fpu_rr_arbiter (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_oh_o,
  output logic       grant_id_o
);

  // Lone requester wins outright; on a tie the one not served last wins
  always_comb begin
    grant_oh_o = 2'b00;
    grant_id_o = 1'b0;
    case (valid_i)
      2'b01: begin
        grant_oh_o = 2'b01;
        grant_id_o = 1'b0;
      end
      2'b10: begin
        grant_oh_o = 2'b10;
        grant_id_o = 1'b1;
      end
      2'b11: begin
        grant_id_o = ~last_grant_i;
        grant_oh_o = last_grant_i ? 2'b01 : 2'b10;
      end
      default: begin
        grant_oh_o = 2'b00;
        grant_id_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Shares one FPU between two requesters: clear pulse, act until done/timeout, tagged response.
// Latency: CLR_CYCLES + FPU time (or TIMEOUT) + 1 cycle to rsp_valid; illegal opcodes 1 cycle.
// Backpressure: one op in flight; req_ready only in IDLE, response held until rsp_ready.
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int CLR_CYCLES = 1
) (
  input logic               wb_clk_i,
  input logic               wb_rst_ni,
  fpu_op_scheduler_if.slave bus
);

  localparam int CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  fpu_cmd_t         fpu_cmd_q;
  fpu_rsp_t         rsp_q;
  logic             rsp_valid_q;
  logic             fpu_rstp_q;
  logic             fpu_act_q;
  logic             busy_q;

  logic [1:0]       grant_oh;
  logic             grant_id;
  logic [1:0]       req_ready_d;
  logic             xfer_d;
  fpu_cmd_t         cmd_d;

  fpu_rr_arbiter u_arb (
    .valid_i      (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_oh_o   (grant_oh),
    .grant_id_o   (grant_id)
  );

  // Accept only in IDLE and never while reset is applied
  always_comb begin
    req_ready_d = (state_q == ST_IDLE && wb_rst_ni) ? grant_oh : 2'b00;
    xfer_d      = |(bus.req_valid & req_ready_d);
  end

  // Pick the granted requester's slice of the packed command buses
  always_comb begin
    cmd_d    = '0;
    cmd_d.a  = grant_id ? bus.req_a[63:32]     : bus.req_a[31:0];
    cmd_d.b  = grant_id ? bus.req_b[63:32]     : bus.req_b[31:0];
    cmd_d.op = grant_id ? bus.req_opcode[5:3]  : bus.req_opcode[2:0];
    cmd_d.rm = grant_id ? bus.req_rm[5:3]      : bus.req_rm[2:0];
  end

  // Sequencer: all FPU controls and response fields are registered here
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      fpu_cmd_q    <= '0;
      rsp_q        <= '0;
      rsp_valid_q  <= 1'b0;
      fpu_rstp_q   <= 1'b1;
      fpu_act_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fpu_rstp_q <= 1'b0;
          if (xfer_d) begin
            last_grant_q <= grant_id;
            rsp_q.id     <= grant_id;
            busy_q       <= 1'b1;
            if (cmd_d.op <= OP_MAX) begin
              state_q    <= ST_CLEAR;
              cnt_q      <= '0;
              fpu_cmd_q  <= cmd_d;
              fpu_rstp_q <= 1'b1;
            end else begin
              // Unsupported opcode: answer immediately, FPU left alone
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_q.result  <= '0;
              rsp_q.flags   <= FLAGS_INV_ONLY;
              rsp_q.timeout <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            fpu_rstp_q <= 1'b0;
            fpu_act_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // done takes priority over the terminal count
          if (bus.fpu_done || cnt_q == RUN_LAST) begin
            state_q       <= ST_RESP;
            fpu_act_q     <= 1'b0;
            fpu_cmd_q     <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_q.result  <= bus.fpu_done ? bus.fpu_out : '0;
            rsp_q.flags   <= bus.fpu_done ? bus.fpu_flags : '0;
            rsp_q.timeout <= ~bus.fpu_done;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_d;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_q.id;
  assign bus.rsp_result  = rsp_q.result;
  assign bus.rsp_flags   = rsp_q.flags;
  assign bus.rsp_timeout = rsp_q.timeout;
  assign bus.busy        = busy_q;
  assign bus.fpu_in1     = fpu_cmd_q.a;
  assign bus.fpu_in2     = fpu_cmd_q.b;
  assign bus.fpu_opcode  = fpu_cmd_q.op;
  assign bus.fpu_round   = fpu_cmd_q.rm;
  assign bus.fpu_rstp    = fpu_rstp_q;
  assign bus.fpu_act     = fpu_act_q;

endmodule
